// File: rtl/timecounter.sv
// ============================================================================
// Module      : timecounter
// Description : Time-of-day counter (hh:mi:ss) with an internal one-second
//               prescaler and a freeze/inc/dec/sel front-panel edit port.
//               dayroll pulses for one cycle on the 23:59:59 -> 00:00:00
//               run-mode rollover and feeds datecounter.dayroll.
// Ports       : clk      - system clock, rising edge
//               rst      - asynchronous reset, active low
//               freeze   - 1 = hold time and enable edits, 0 = run
//               inc/dec  - single-cycle step pulses for the selected field
//               sel      - 00 none, 01 seconds, 10 minutes, 11 hours
//               ss/mi/hh - registered seconds, minutes, hours
//               dayroll  - registered one-cycle day-rollover pulse
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timecounter #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       freeze,
    input  logic       inc,
    input  logic       dec,
    input  logic [1:0] sel,
    output logic [5:0] ss,
    output logic [5:0] mi,
    output logic [4:0] hh,
    output logic       dayroll
);

    localparam int              c_PW        = $clog2(TICK_DIV);
    localparam logic [c_PW-1:0] c_TICK_LAST = c_PW'(TICK_DIV - 1);

    localparam logic [1:0] c_SEL_SS = 2'b01;
    localparam logic [1:0] c_SEL_MI = 2'b10;
    localparam logic [1:0] c_SEL_HH = 2'b11;

    logic [c_PW-1:0] r_presc;
    logic [5:0]      r_ss;
    logic [5:0]      r_mi;
    logic [4:0]      r_hh;
    logic            r_dayroll;

    logic w_ss_max;
    logic w_mi_max;
    logic w_hh_max;
    logic w_step;
    logic w_tick;

    assign w_ss_max = (r_ss == 6'd59);
    assign w_mi_max = (r_mi == 6'd59);
    assign w_hh_max = (r_hh == 5'd23);
    // Exactly one of inc/dec requests a step; both together cancel out.
    assign w_step   = inc ^ dec;
    assign w_tick   = (r_presc == c_TICK_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc   <= '0;
            r_ss      <= 6'd0;
            r_mi      <= 6'd0;
            r_hh      <= 5'd0;
            r_dayroll <= 1'b0;
        end else begin
            r_dayroll <= 1'b0;
            if (freeze) begin
                // Freeze has priority over a coincident tick; the prescaler
                // restarts from zero when run mode resumes.
                r_presc <= '0;
                if (w_step) begin
                    case (sel)
                        c_SEL_SS: begin
                            if (inc) r_ss <= w_ss_max ? 6'd0 : r_ss + 6'd1;
                            else     r_ss <= (r_ss == 6'd0) ? 6'd59 : r_ss - 6'd1;
                        end
                        c_SEL_MI: begin
                            if (inc) r_mi <= w_mi_max ? 6'd0 : r_mi + 6'd1;
                            else     r_mi <= (r_mi == 6'd0) ? 6'd59 : r_mi - 6'd1;
                        end
                        c_SEL_HH: begin
                            if (inc) r_hh <= w_hh_max ? 5'd0 : r_hh + 5'd1;
                            else     r_hh <= (r_hh == 5'd0) ? 5'd23 : r_hh - 5'd1;
                        end
                        default: ;
                    endcase
                end
            end else if (w_tick) begin
                r_presc <= '0;
                if (w_ss_max) begin
                    r_ss <= 6'd0;
                    if (w_mi_max) begin
                        r_mi <= 6'd0;
                        if (w_hh_max) begin
                            r_hh      <= 5'd0;
                            r_dayroll <= 1'b1;
                        end else begin
                            r_hh <= r_hh + 5'd1;
                        end
                    end else begin
                        r_mi <= r_mi + 6'd1;
                    end
                end else begin
                    r_ss <= r_ss + 6'd1;
                end
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    assign ss      = r_ss;
    assign mi      = r_mi;
    assign hh      = r_hh;
    assign dayroll = r_dayroll;

endmodule

`default_nettype wire
